// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch front end owning the fetch PC, a prefetch FIFO and redirect flush
// Ports:
//   clk            core clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   rom_addr       byte address to the instruction ROM (the fetch PC register)
//   rom_inst       ROM word for rom_addr, combinational in the same cycle
//   redirect_valid flush the FIFO and restart fetch at redirect_pc (word aligned)
//   redirect_pc    new fetch byte address
//   out_valid      FIFO head holds a valid entry
//   out_ready      decode accepts the head this cycle
//   out_inst       head instruction word, NOP_INST when empty
//   out_pc         head instruction PC, 0 when empty
// Optional: define IF_PREFETCH_PERF_EN to add perf_flush_cnt / perf_full_cnt counters.
module if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_full_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem [DEPTH];
  logic          pop, push, full;
  assign full      = cnt_q == (PW+1)'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign pop       = out_valid & out_ready;
  // a pop frees a slot in the same cycle, so a full FIFO still streams at one per cycle
  assign push      = ~redirect_valid & (~full | pop);
  assign rom_addr  = pc_q;
  assign out_inst  = out_valid ? inst_mem[rd_q] : NOP_INST;
  assign out_pc    = out_valid ? pc_mem[rd_q] : 32'h0;
  always_comb begin
    pc_d  = redirect_valid ? {redirect_pc[31:2], 2'b00} : push ? pc_q + 32'd4 : pc_q;
    wr_d  = redirect_valid ? '0 : push ? wr_q + PW'(1) : wr_q;
    rd_d  = redirect_valid ? '0 : pop ? rd_q + PW'(1) : rd_q;
    cnt_d = redirect_valid ? '0 :
            (push & ~pop) ? cnt_q + (PW+1)'(1) :
            (pop & ~push) ? cnt_q - (PW+1)'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_PC;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_q] <= rom_inst;
      pc_mem[wr_q]   <= pc_q;
    end
  end
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] flush_q, full_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= '0;
      full_q  <= '0;
    end else begin
      flush_q <= flush_q + {31'd0, redirect_valid};
      full_q  <= full_q + {31'd0, full & ~pop};
    end
  end
  assign perf_flush_cnt = flush_q;
  assign perf_full_cnt  = full_q;
`endif
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed self-checking bench for if_prefetch
module tb_if_prefetch;
  logic        clk, rst_n, redirect_valid, out_ready, out_valid;
  logic [31:0] rom_addr, rom_inst, redirect_pc, out_inst, out_pc;
  int          checks = 0;
  int          failures = 0;
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_flush_cnt, perf_full_cnt;
`endif
  if_prefetch dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc)
`ifdef IF_PREFETCH_PERF_EN
    , .perf_flush_cnt(perf_flush_cnt), .perf_full_cnt(perf_full_cnt)
`endif
  );
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction
  assign rom_inst = rom(rom_addr);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(negedge clk);
  endtask
  task automatic head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_inst"}, out_inst, rom(pc));
  endtask
  task automatic empty(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_pc"}, out_pc, 32'h0);
    chk({tag, "_inst"}, out_inst, 32'h0000_0013);
  endtask
  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    #2;
    empty("reset");
    chk("reset_addr", rom_addr, 32'h0);
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt();
      head("stream", 32'(4 * i));
      chk("stream_addr", rom_addr, 32'(4 * i + 4));
    end
    out_ready = 1'b0;
    nxt();
    head("pre_rst", 32'hC);
    #2 rst_n = 1'b0;
    #1;
    empty("async_rst");
    chk("async_rst_addr", rom_addr, 32'h0);
    nxt();
    rst_n = 1'b1;
    repeat (10) nxt();
    head("stall", 32'h0);
    chk("stall_addr", rom_addr, 32'h10);
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      nxt();
      head("drain", 32'(4 * i));
      chk("full_pp_addr", rom_addr, 32'(32'h10 + 4 * i));
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    nxt();
    empty("redir_pop");
    chk("redir_pop_addr", rom_addr, 32'h200);
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    nxt();
    head("after_redir", 32'h200);
    nxt();
    nxt();
    head("three_q", 32'h200);
    chk("three_q_addr", rom_addr, 32'h20C);
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    nxt();
    empty("redir3");
    chk("redir3_addr", rom_addr, 32'h100);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    nxt();
    head("redir3_first", 32'h100);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    nxt();
    empty("b2b_1");
    chk("b2b_1_addr", rom_addr, 32'h300);
    redirect_pc = 32'hFFFF_FFF8;
    nxt();
    empty("b2b_2");
    chk("b2b_2_addr", rom_addr, 32'hFFFF_FFF8);
    redirect_valid = 1'b0;
    nxt();
    head("wrap0", 32'hFFFF_FFF8);
    nxt();
    head("wrap1", 32'hFFFF_FFFC);
    nxt();
    head("wrap2", 32'h0);
    chk("wrap_addr", rom_addr, 32'h4);
`ifdef IF_PREFETCH_PERF_EN
    chk("perf_flush", perf_flush_cnt, 32'd4);
    chk("perf_full", perf_full_cnt, 32'd6);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
